// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between instruction fetch and the data stage.
// Data has priority; fetch is forced through after STARVE_LIM consecutive data grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIM = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_if_o,
  output logic        stall_dm_o
);

  localparam int unsigned CntW = $clog2(STARVE_LIM + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIM);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  state_e          state_q, state_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     dm_rdata_q, dm_rdata_d;
  logic            if_ready_q, if_ready_d;
  logic            dm_ready_q, dm_ready_d;
  logic [CntW-1:0] starve_q, starve_d;

  logic if_elig, dm_elig, grant_fetch, grant_data;

  // A requester whose ready is high this cycle is consuming its result, not asking again.
  assign if_elig     = if_req_i & ~if_ready_q;
  assign dm_elig     = dm_req_i & ~dm_ready_q;
  assign grant_fetch = if_elig & (~dm_elig | (starve_q == CntMax));
  assign grant_data  = dm_elig & ~grant_fetch;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    starve_d    = starve_q;
    unique case (state_q)
      StIdle: begin
        if (grant_fetch) begin
          state_d    = StFetch;
          mem_addr_d = if_addr_i;
          mem_we_d   = 1'b0;
          starve_d   = '0;
        end else if (grant_data) begin
          state_d     = StData;
          mem_addr_d  = dm_addr_i;
          mem_we_d    = dm_we_i;
          mem_wdata_d = dm_wdata_i;
          if (if_req_i) begin
            starve_d = (starve_q == CntMax) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end
      end
      StFetch: begin
        if (mem_ack_i) begin
          state_d    = StIdle;
          if_ready_d = 1'b1;
          if_rdata_d = mem_rdata_i;
        end
      end
      StData: begin
        if (mem_ack_i) begin
          state_d    = StIdle;
          dm_ready_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      starve_q    <= starve_d;
    end
  end

  assign mem_req_o   = (state_q != StIdle);
  assign mem_we_o    = mem_we_q & mem_req_o;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign dm_ready_o  = dm_ready_q;
  assign stall_if_o  = if_req_i & ~if_ready_q;
  assign stall_dm_o  = dm_req_i & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; each check compares against hand-derived values.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_req, mem_we, stall_if, stall_dm;

  int errs = 0;
  int checks = 0;

  mem_port_arbiter #(.STARVE_LIM(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_rdata_o (if_rdata),
    .if_ready_o (if_ready),
    .dm_req_i   (dm_req),
    .dm_we_i    (dm_we),
    .dm_addr_i  (dm_addr),
    .dm_wdata_i (dm_wdata),
    .dm_rdata_o (dm_rdata),
    .dm_ready_o (dm_ready),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_ack_i  (mem_ack),
    .stall_if_o (stall_if),
    .stall_dm_o (stall_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    #12;
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_readies", {30'd0, if_ready, dm_ready}, 0);
    check("rst_stall_if", {31'd0, stall_if}, 1);
    if_req = 1'b0;
    #1;
    check("rst_stall_if_low", {31'd0, stall_if}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single fetch, ack in first access cycle
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    check("f1_c0_stall_if", {31'd0, stall_if}, 1);
    check("f1_c0_mem_req", {31'd0, mem_req}, 0);
    tick();
    check("f1_c1_req_we", {30'd0, mem_req, mem_we}, 32'b10);
    check("f1_c1_addr", mem_addr, 32'h100);
    check("f1_c1_stall_if", {31'd0, stall_if}, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    check("f1_c2_ready", {30'd0, if_ready, dm_ready}, 32'b10);
    check("f1_c2_rdata", if_rdata, 32'h0050_0093);
    check("f1_c2_mem_req", {31'd0, mem_req}, 0);
    check("f1_c2_stall_if", {31'd0, stall_if}, 0);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();
    check("f1_c3_ready", {30'd0, if_ready, dm_ready}, 0);

    // Store, ack in third access cycle
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("st_req_we", {30'd0, mem_req, mem_we}, 32'b11);
      check("st_addr", mem_addr, 32'h2004);
      check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("st_not_ready", {31'd0, dm_ready}, 0);
      check("st_stall_dm", {31'd0, stall_dm}, 1);
      if (c == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      end
    end
    tick();
    check("st_ready", {30'd0, if_ready, dm_ready}, 32'b01);
    check("st_rdata_held", dm_rdata, 0);
    check("st_idle_we", {30'd0, mem_req, mem_we}, 0);
    dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    tick();
    check("st_ready_gone", {31'd0, dm_ready}, 0);

    // Load then fetch back-to-back
    dm_req = 1'b1; dm_addr = 32'h3000; if_req = 1'b1; if_addr = 32'h104;
    tick();
    check("lf_load_addr", mem_addr, 32'h3000);
    check("lf_load_req_we", {30'd0, mem_req, mem_we}, 32'b10);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    check("lf_dm_ready", {30'd0, if_ready, dm_ready}, 32'b01);
    check("lf_dm_rdata", dm_rdata, 32'h1111_2222);
    check("lf_idle", {31'd0, mem_req}, 0);
    check("lf_stalls", {30'd0, stall_if, stall_dm}, 32'b10);
    dm_req = 1'b0; mem_ack = 1'b0;
    tick();
    check("lf_fetch_req", {31'd0, mem_req}, 1);
    check("lf_fetch_addr", mem_addr, 32'h104);
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    tick();
    check("lf_if_ready", {30'd0, if_ready, dm_ready}, 32'b10);
    check("lf_if_rdata", if_rdata, 32'h3333_4444);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Starvation bound: data, data, then fetch forced ahead of pending data
    dm_req = 1'b1; dm_addr = 32'hA0; if_req = 1'b1; if_addr = 32'h200;
    tick();
    check("sv_g1_data", mem_addr, 32'hA0);
    mem_ack = 1'b1;
    tick();
    check("sv_g1_ready", {31'd0, dm_ready}, 1);
    if_req = 1'b0; mem_ack = 1'b0; dm_addr = 32'hA4;
    tick();
    check("sv_gap1_idle", {31'd0, mem_req}, 0);
    if_req = 1'b1;
    tick();
    check("sv_g2_data", mem_addr, 32'hA4);
    mem_ack = 1'b1;
    tick();
    check("sv_g2_ready", {31'd0, dm_ready}, 1);
    if_req = 1'b0; mem_ack = 1'b0; dm_addr = 32'hA8;
    tick();
    if_req = 1'b1;
    tick();
    check("sv_g3_fetch", mem_addr, 32'h200);
    check("sv_g3_we", {31'd0, mem_we}, 0);
    mem_ack = 1'b1; mem_rdata = 32'h5555_6666;
    tick();
    check("sv_g3_ready", {30'd0, if_ready, dm_ready}, 32'b10);
    mem_ack = 1'b0;
    tick();
    check("sv_g4_data", mem_addr, 32'hA8);
    check("sv_g4_req", {31'd0, mem_req}, 1);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_8888;
    tick();
    check("sv_g4_ready", {31'd0, dm_ready}, 1);
    check("sv_g4_rdata", dm_rdata, 32'h7777_8888);
    dm_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Reset mid-access
    dm_req = 1'b1; dm_addr = 32'h4000;
    tick();
    check("rm_req", {31'd0, mem_req}, 1);
    tick();
    rst = 1'b1;
    #1;
    check("rm_req_abort", {31'd0, mem_req}, 0);
    check("rm_no_ready", {31'd0, dm_ready}, 0);
    check("rm_rdata_clr", dm_rdata, 0);
    check("rm_stall_dm", {31'd0, stall_dm}, 1);
    tick();
    rst = 1'b0;
    check("rm_after_rel", {31'd0, mem_req}, 0);
    tick();
    check("rm_restart_req", {31'd0, mem_req}, 1);
    check("rm_restart_addr", mem_addr, 32'h4000);
    mem_ack = 1'b1; mem_rdata = 32'h9999_AAAA;
    tick();
    check("rm_ready", {31'd0, dm_ready}, 1);
    check("rm_rdata", dm_rdata, 32'h9999_AAAA);
    dm_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Spurious ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hBBBB_CCCC;
    tick();
    check("sp_ready1", {30'd0, if_ready, dm_ready}, 0);
    check("sp_req1", {31'd0, mem_req}, 0);
    tick();
    check("sp_ready2", {30'd0, if_ready, dm_ready}, 0);
    check("sp_rdata", dm_rdata, 32'h9999_AAAA);
    mem_ack = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
